// File: rtl/gf180mcu_osu_sc_pkg.sv
// Shared encodings and parameter limits for the gf180mcu OSU pipelined complex-gate cells.
`timescale 1ns/10ps
package gf180mcu_osu_sc_pkg;

  localparam logic MODE_OAI = 1'b0;
  localparam logic MODE_AOI = 1'b1;

  localparam int NGRP_MIN   = 2;
  localparam int NGRP_MAX   = 4;
  localparam int GW_MIN     = 1;
  localparam int GW_MAX     = 4;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  function automatic bit in_range(input int val, input int lo, input int hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp9t3v3__oai_pipe_stage.sv
// One {data, valid} pipeline register with scan mux; scan shifts data only, valid holds.
`timescale 1ns/10ps
module gf180mcu_osu_sc_gp9t3v3__oai_pipe_stage
  import gf180mcu_osu_sc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic se,
  input  logic si,
  input  logic d_in,
  input  logic v_in,
  output logic d_q,
  output logic v_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
      v_q <= 1'b0;
    end else if (se) begin
      d_q <= si;
    end else if (en) begin
      d_q <= d_in;
      v_q <= v_in;
    end
  end

endmodule

// File: rtl/gf180mcu_osu_sc_gp9t3v3__oai_pipe.sv
// Pipelined OAI/AOI complex gate with valid tag and STAGES-deep register chain.
// Define GF180MCU_OSU_SC_SCAN_EN to add the SE/SI/SO scan ports.
`timescale 1ns/10ps
`celldefine
module gf180mcu_osu_sc_gp9t3v3__oai_pipe
  import gf180mcu_osu_sc_pkg::*;
#(
  parameter int NGRP   = 2,
  parameter int GW     = 2,
  parameter int STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 R,
  input  logic                 EN,
  input  logic                 MODE,
  input  logic                 VI,
  input  logic [NGRP*GW-1:0]   A,
  output logic                 Y,
  output logic                 VO
`ifdef GF180MCU_OSU_SC_SCAN_EN
  ,
  input  logic                 SE,
  input  logic                 SI,
  output logic                 SO
`endif
);

  if (!in_range(NGRP, NGRP_MIN, NGRP_MAX) || !in_range(GW, GW_MIN, GW_MAX) ||
      !in_range(STAGES, STAGES_MIN, STAGES_MAX)) begin : g_bad_param
    $error("oai_pipe: parameter out of supported range");
  end

  logic se_i;
  logic si_i;

`ifdef GF180MCU_OSU_SC_SCAN_EN
  assign se_i = SE;
  assign si_i = SI;
`else
  assign se_i = 1'b0;
  assign si_i = 1'b0;
`endif

  logic [NGRP-1:0] grp_or;
  logic [NGRP-1:0] grp_and;

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    assign grp_or[g]  = |A[g*GW +: GW];
    assign grp_and[g] = &A[g*GW +: GW];
  end

  logic f_raw;
  logic x_tag;
  logic f;

  assign f_raw = (MODE == MODE_OAI) ? ~(&grp_or) : ~(|grp_and);
  // x_tag ^ x_tag is 0 for known inputs but X when any A/MODE bit is X,
  // so unknowns reach F instead of being masked by a controlling group value.
  assign x_tag = ^{MODE, A};
  assign f     = f_raw ^ (x_tag ^ x_tag);

  logic [STAGES-1:0] d_q;
  logic [STAGES-1:0] v_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic d_in;
    logic v_in;
    logic si_k;

    if (k == 0) begin : g_head
      assign d_in = f;
      assign v_in = VI;
      assign si_k = si_i;
    end else begin : g_body
      assign d_in = d_q[k-1];
      assign v_in = v_q[k-1];
      assign si_k = d_q[k-1];
    end

    gf180mcu_osu_sc_gp9t3v3__oai_pipe_stage u_stage (
      .clk  (CLK),
      .rst  (R),
      .en   (EN),
      .se   (se_i),
      .si   (si_k),
      .d_in (d_in),
      .v_in (v_in),
      .d_q  (d_q[k]),
      .v_q  (v_q[k])
    );
  end

  assign Y  = d_q[STAGES-1];
  assign VO = v_q[STAGES-1];

`ifdef GF180MCU_OSU_SC_SCAN_EN
  assign SO = d_q[STAGES-1];
`endif

  specify
    (CLK => Y)  = 0;
    (CLK => VO) = 0;
  endspecify

endmodule
`endcelldefine

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__oai_pipe.sv
// Scoreboard bench for the OAI/AOI pipe (NGRP=2, GW=2, STAGES=2); scan checks under GF180MCU_OSU_SC_SCAN_EN.
`timescale 1ns/10ps
module tb_gf180mcu_osu_sc_gp9t3v3__oai_pipe;

  localparam int NGRP   = 2;
  localparam int GW     = 2;
  localparam int STAGES = 2;

  logic             CLK = 1'b0;
  logic             R   = 1'b1;
  logic             EN  = 1'b0;
  logic             MODE = 1'b0;
  logic             VI  = 1'b0;
  logic [NGRP*GW-1:0] A = '0;
  logic             Y;
  logic             VO;
`ifdef GF180MCU_OSU_SC_SCAN_EN
  logic             SE = 1'b0;
  logic             SI = 1'b0;
  logic             SO;
`endif

  gf180mcu_osu_sc_gp9t3v3__oai_pipe #(
    .NGRP   (NGRP),
    .GW     (GW),
    .STAGES (STAGES)
  ) dut (
    .CLK  (CLK),
    .R    (R),
    .EN   (EN),
    .MODE (MODE),
    .VI   (VI),
    .A    (A),
    .Y    (Y),
    .VO   (VO)
`ifdef GF180MCU_OSU_SC_SCAN_EN
    ,
    .SE   (SE),
    .SI   (SI),
    .SO   (SO)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic v;
    logic y;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp = '0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   scan_active = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reset leaves STAGES-1 cleared entries ahead of the first loaded one.
  task automatic flush_sb();
    sb_q.delete();
    for (int i = 0; i < STAGES - 1; i++) sb_q.push_back('0);
    last_exp = '0;
  endtask

  task automatic issue(input logic mode, input logic [3:0] a, input logic vi, input logic exp_y);
    exp_t e;
    @(negedge CLK);
    EN = 1'b1; MODE = mode; A = a; VI = vi;
    e.v = vi;
    e.y = exp_y;
    sb_q.push_back(e);
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(negedge CLK);
      EN = 1'b0; A = ~A; VI = ~VI; MODE = ~MODE;
    end
  endtask

  // Reset held across one enabled edge that would otherwise load F=1, VI=1.
  task automatic do_reset();
    @(negedge CLK);
    EN = 1'b1; MODE = 1'b0; A = 4'b0011; VI = 1'b1;
    R = 1'b1;
    #1;
    check("rst_y_immediate", Y, 1'b0);
    check("rst_vo_immediate", VO, 1'b0);
    flush_sb();
    @(negedge CLK);
    R = 1'b0; EN = 1'b0;
    #1;
    check("rst_y_release", Y, 1'b0);
    check("rst_vo_release", VO, 1'b0);
  endtask

  initial begin : monitor
    logic en_s, r_s, sc_s;
    forever begin
      @(posedge CLK);
      en_s = EN; r_s = R; sc_s = scan_active;
      #1;
      if (!r_s && !sc_s) begin
        if (en_s) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL sb_underflow: got empty queue, expected an entry at %0t", $time);
          end else begin
            last_exp = sb_q.pop_front();
          end
        end
        check("pipe_y", Y, last_exp.y);
        check("pipe_vo", VO, last_exp.v);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    #1;
    check("init_y_in_reset", Y, 1'b0);
    check("init_vo_in_reset", VO, 1'b0);
    do_reset();

    // Cleared pipe with VI=0 and F=0 keeps Y/VO low.
    issue(1'b0, 4'b1111, 1'b0, 1'b0);
    issue(1'b0, 4'b1111, 1'b0, 1'b0);

    // OAI: F = ~((A1|A0) & (A3|A2))
    issue(1'b0, 4'b0101, 1'b1, 1'b0);
    issue(1'b0, 4'b0011, 1'b1, 1'b1);
    issue(1'b0, 4'b0000, 1'b1, 1'b1);
    issue(1'b0, 4'b1111, 1'b1, 1'b0);
    issue(1'b0, 4'b1000, 1'b0, 1'b1);

    // AOI: F = ~((A1&A0) | (A3&A2)); mode flips with OAI data still in flight.
    issue(1'b1, 4'b0011, 1'b1, 1'b0);
    issue(1'b1, 4'b0110, 1'b1, 1'b1);
    issue(1'b1, 4'b0000, 1'b1, 1'b1);
    issue(1'b1, 4'b1100, 1'b1, 1'b0);
    issue(1'b1, 4'b1111, 1'b0, 1'b0);

    // Stall with inputs toggling while EN=0.
    do_reset();
    issue(1'b0, 4'b0011, 1'b1, 1'b1);
    stall(3);
    issue(1'b0, 4'b0101, 1'b1, 1'b0);
    issue(1'b0, 4'b0000, 1'b0, 1'b1);
    stall(2);
    issue(1'b0, 4'b1111, 1'b0, 1'b0);

    // Mid-stream reset discards two valid entries.
    issue(1'b0, 4'b0011, 1'b1, 1'b1);
    issue(1'b1, 4'b0000, 1'b1, 1'b1);
    do_reset();
    issue(1'b0, 4'b1111, 1'b0, 1'b0);
    issue(1'b0, 4'b1111, 1'b0, 1'b0);
    issue(1'b0, 4'b1111, 1'b0, 1'b0);

`ifdef GF180MCU_OSU_SC_SCAN_EN
    issue(1'b1, 4'b0000, 1'b1, 1'b1);
    issue(1'b1, 4'b0000, 1'b1, 1'b1);
    issue(1'b1, 4'b0000, 1'b1, 1'b1);
    @(negedge CLK);
    scan_active = 1'b1;
    EN = 1'b1; SE = 1'b1; SI = 1'b1;
    @(negedge CLK);
    SI = 1'b0;
    @(negedge CLK);
    check("scan_so_first", SO, 1'b1);
    check("scan_vo_hold_1", VO, last_exp.v);
    @(negedge CLK);
    check("scan_so_second", SO, 1'b0);
    check("scan_vo_hold_2", VO, last_exp.v);
    SE = 1'b0;
    do_reset();
    scan_active = 1'b0;
    issue(1'b0, 4'b0011, 1'b1, 1'b1);
    issue(1'b0, 4'b1111, 1'b0, 1'b0);
`endif

    issue(1'b0, 4'b1111, 1'b0, 1'b0);
    issue(1'b0, 4'b1111, 1'b0, 1'b0);
    @(negedge CLK);
    EN = 1'b0;
    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_osu_sc_gp9t3v3__oai_pipe.md
GF180MCU_OSU_SC_GP9T3V3__OAI_PIPE -- requirements
Module: gf180mcu_osu_sc_gp9t3v3__oai_pipe

Interface
REQ-001 Parameter NGRP, default 2: number of input groups, range 2..4.
REQ-002 Parameter GW, default 2: inputs per group, range 1..4.
REQ-003 Parameter STAGES, default 2: pipeline depth in registers, range 1..4.
REQ-004 CLK  input  1: single clock; all state SHALL change only on rising CLK edge, except on reset.
REQ-005 R  input  1: reset, asynchronous and active-high.
REQ-006 EN  input  1: pipeline advance enable.
REQ-007 MODE  input  1: 0 = OAI (OR groups, then NAND); 1 = AOI (AND groups, then NOR).
REQ-008 VI  input  1: input-valid qualifier for A.
REQ-009 A  input  NGRP*GW: data inputs; group g is A[g*GW +: GW].
REQ-010 Y  output  1: registered function result.
REQ-011 VO  output  1: registered valid, aligned with Y.

Function
REQ-012 Combinational term F: MODE=0 SHALL give F = NOT(AND over g of (OR of group g)); MODE=1 SHALL give F = NOT(OR over g of (AND of group g)).
REQ-013 Stage 0 SHALL capture {F, VI} on a rising CLK edge with EN=1; stage k (k>=1) SHALL capture stage k-1 on the same edge.
REQ-014 With EN=0, all stages SHALL hold; MODE, A and VI SHALL be ignored.
REQ-015 Y and VO SHALL be driven directly from the last stage; latency from A/VI sampling to Y/VO SHALL be exactly STAGES enabled edges.
REQ-016 A MODE change SHALL affect only data sampled from that edge onward; data in flight SHALL be unaffected.
REQ-017 Data bits SHALL propagate irrespective of VI; VO is a tag only and SHALL never gate Y.
REQ-018 STAGES=1 SHALL reduce to a single register with no internal stages.
REQ-019 Any X on A or MODE SHALL yield X in F; F SHALL NOT be silently resolved.

Reset
REQ-020 R=1 SHALL immediately clear all stage data bits and valid bits to 0, so that Y=0 and VO=0, independent of CLK.
REQ-021 While R=1, clock edges SHALL have no effect; the first enabled edge after R falls SHALL load stage 0 normally.
REQ-022 Reset asserted mid-stream SHALL discard all in-flight entries; no partial outputs SHALL appear after release.

Configuration
REQ-023 Macro GF180MCU_OSU_SC_SCAN_EN, when defined, SHALL add ports SE (input 1), SI (input 1) and SO (output 1).
REQ-024 With the macro defined and SE=1, each edge SHALL shift the data bits SI -> stage 0 -> ... -> last stage, regardless of EN; SO SHALL equal the last-stage data bit (= Y); valid bits SHALL hold.
REQ-025 With the macro defined and SE=0, behaviour SHALL be identical to REQ-012..REQ-019.
REQ-026 Without the macro, the SE, SI and SO ports SHALL NOT exist.
REQ-027 Reset SHALL override scan in both builds.

Structure
REQ-028 Shared package gf180mcu_osu_sc_pkg SHALL hold the MODE encodings (MODE_OAI=0, MODE_AOI=1) and the parameter range limits.
REQ-029 One sub-module, gf180mcu_osu_sc_gp9t3v3__oai_pipe_stage, SHALL implement a single {data, valid} stage, including the scan mux; the top SHALL instantiate it STAGES times.
REQ-030 The top SHALL contain a specify block with zero-delay paths CLK=>Y and CLK=>VO.
REQ-031 The top SHALL carry the celldefine marking and timescale 1ns/10ps.

Verification (NGRP=2, GW=2, STAGES=2)
REQ-032 Reset: pulse R=1 between clock edges -> Y=0 and VO=0 immediately; both stay 0 for 2 edges after release with VI=0.
REQ-033 OAI: MODE=0, EN=1, VI=1; A=4'b0101 then 4'b0011 on consecutive edges -> Y=0 then Y=1 after 2 edges; VO=1 on both.
REQ-034 AOI: MODE=1, A=4'b0011 then 4'b0110 -> Y=0 then Y=1 after 2 edges.
REQ-035 Stall: load A=4'b0011 (MODE=0), set EN=0 for 3 edges while toggling A -> Y/VO frozen; Y=1 emerges on the 2nd enabled edge overall.
REQ-036 Mid-stream reset: two valid entries in flight, assert R -> Y=0 and VO=0 at once; no stale entry appears after release.
REQ-037 Scan build: SE=1, shift SI=1,0 -> SO=1 after 2 edges, then SO=0; VO unchanged throughout.
